// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 16;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUOP    = 4;
    localparam int CTRL_ALUSRC   = 6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: ctrl/data under valid/ready,
// with bubble, flush, optional skid entry and stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              noop_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    stage_state_t      state_q;
    stage_state_t      state_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              rdy_q;
    logic              accept;
    logic              emit;
    logic              load_main;
    logic              load_skid;
    logic              move_skid;
    logic [CTRL_W-1:0] in_ctrl_eff;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_ctrl_o  = main_ctrl_q;
    assign out_data_o  = main_data_q;

    // Without the skid entry, ready must look through to downstream.
    assign in_ready_o = SKID_EN ? rdy_q
                                : (~out_valid_o | out_ready_i);

    assign accept      = in_valid_i & in_ready_o;
    assign emit        = out_valid_o & out_ready_i;
    assign in_ctrl_eff = noop_i ? '0 : in_ctrl_i;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_FULL;
                    load_main = 1'b1;
                end
            end
            ST_FULL: begin
                unique case (1'b1)
                    accept & emit: load_main = 1'b1;
                    accept & ~emit: begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end
                    ~accept & emit: state_d = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_SKID: begin
                if (emit) begin
                    state_d   = ST_FULL;
                    move_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            rdy_q       <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != ST_SKID);
            // Flush drops control only; data keeps its old value.
            if (flush_i) begin
                main_ctrl_q <= '0;
            end else if (load_main) begin
                main_ctrl_q <= in_ctrl_eff;
                main_data_q <= in_data_i;
            end else if (move_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
            end
            if (load_skid && !flush_i) begin
                skid_ctrl_q <= in_ctrl_eff;
                skid_data_q <= in_data_i;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (out_valid_o & ~out_ready_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (accept & noop_i & ~flush_i),
        .cnt_o (bubble_cnt_o)
    );

endmodule
